irq_priority_arbiter: RTL and testbench

Sequential front end for the 4-to-2 priority encoding path. It captures rising edges on four asynchronous-to-service request lines into sticky pending bits. It selects the highest-priority pending line (line 3 highest, line 0 lowest, matching the encoder's priority order) and presents it as a held 2-bit id under a valid/ack handshake to the downstream consumer. It also counts completed grants and flags lost requests.

---
 rtl/irq_priority_arbiter.sv | 88 ++++++++
 tb/tb_irq_priority_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_arbiter.sv
// Captures rising edges on four request lines into sticky pending bits and
// presents the highest-priority pending line as a held grant under valid/ack.
module irq_priority_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_lines,
    input  logic       ack,
    input  logic       clr_overrun,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic       overrun,
    output logic [7:0] grant_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [3:0] prev_req;
    logic [3:0] req_edge;
    logic [3:0] clear_mask;
    logic [3:0] pending_next;
    logic [1:0] top_id;

    // An ack only clears the line actually being granted; a fresh edge on that
    // same line re-arms it, so the new request is never lost.
    always_comb begin
        req_edge   = req_lines & ~prev_req;
        clear_mask = 4'b0000;
        if (state == GRANT && ack) begin
            clear_mask[irq_id] = 1'b1;
        end
        pending_next = (pending & ~clear_mask) | req_edge;
    end

    always_comb begin
        casez (pending)
            4'b1???: top_id = 2'd3;
            4'b01??: top_id = 2'd2;
            4'b001?: top_id = 2'd1;
            default: top_id = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prev_req    <= 4'b0000;
            pending     <= 4'b0000;
            overrun     <= 1'b0;
            irq_valid   <= 1'b0;
            irq_id      <= 2'b00;
            grant_count <= 8'd0;
        end else begin
            prev_req <= req_lines;
            pending  <= pending_next;

            // A new overrun takes precedence over a simultaneous clear.
            if (|(req_edge & pending & ~clear_mask)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        irq_id    <= top_id;
                        irq_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        irq_valid   <= 1'b0;
                        grant_count <= grant_count + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench for irq_priority_arbiter: a per-line behavioural model is
// compared every cycle, plus hand-computed literal checks at key points.
module tb_irq_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_lines;
    logic       ack;
    logic       clr_overrun;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       overrun;
    logic [7:0] grant_count;

    int errors = 0;
    int checks = 0;

    irq_priority_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_lines   (req_lines),
        .ack         (ack),
        .clr_overrun (clr_overrun),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .pending     (pending),
        .overrun     (overrun),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: one pending flag per line, a grant slot and a counter.
    bit m_pend [4] = '{0, 0, 0, 0};
    bit m_prev [4] = '{0, 0, 0, 0};
    bit m_valid    = 0;
    int m_id       = 0;
    int m_count    = 0;
    bit m_ov       = 0;

    always @(posedge clk or posedge rst) begin
        bit rise, done, cleared, ov_set;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] <= 0;
                m_prev[i] <= 0;
            end
            m_valid <= 0;
            m_id    <= 0;
            m_count <= 0;
            m_ov    <= 0;
        end else begin
            done   = m_valid && ack;
            ov_set = 0;
            for (int i = 0; i < 4; i++) begin
                rise    = req_lines[i] && !m_prev[i];
                cleared = done && (m_id == i);
                if (rise && m_pend[i] && !cleared) ov_set = 1;
                m_pend[i] <= (m_pend[i] && !cleared) || rise;
                m_prev[i] <= req_lines[i];
            end
            if (ov_set) m_ov <= 1;
            else if (clr_overrun) m_ov <= 0;
            if (m_valid) begin
                if (ack) begin
                    m_valid <= 0;
                    m_count <= (m_count + 1) % 256;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i]) begin
                        m_valid <= 1;
                        m_id    <= i;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        int mp;
        if (rst === 1'b0) begin
            mp = 0;
            for (int i = 0; i < 4; i++) if (m_pend[i]) mp += (1 << i);
            check_output("model_valid", int'(irq_valid), int'(m_valid));
            check_output("model_pending", int'(pending), mp);
            check_output("model_overrun", int'(overrun), int'(m_ov));
            check_output("model_count", int'(grant_count), m_count);
            if (m_valid) check_output("model_id", int'(irq_id), m_id);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic a, input logic clr);
        req_lines   = req;
        ack         = a;
        clr_overrun = clr;
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (irq_valid) seen = 1;
        end
        if (!seen) check_output("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(4'b0000, 0, 0);
        tick(2);
        rst = 1'b0;
        check_output("reset_valid", int'(irq_valid), 0);
        check_output("reset_id", int'(irq_id), 0);
        check_output("reset_pending", int'(pending), 0);
        check_output("reset_overrun", int'(overrun), 0);
        check_output("reset_count", int'(grant_count), 0);

        // Single request on line 0
        apply_stimulus(4'b0001, 0, 0);
        tick(1);
        check_output("single_pending", int'(pending), 4'b0001);
        check_output("single_not_yet_valid", int'(irq_valid), 0);
        tick(1);
        check_output("single_valid", int'(irq_valid), 1);
        check_output("single_id", int'(irq_id), 0);
        apply_stimulus(4'b0001, 1, 0);
        tick(1);
        check_output("single_ack_pending", int'(pending), 0);
        check_output("single_ack_valid", int'(irq_valid), 0);
        check_output("single_ack_count", int'(grant_count), 1);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);

        // Priority and hold
        apply_stimulus(4'b0011, 0, 0);
        tick(2);
        check_output("prio_first_id", int'(irq_id), 1);
        apply_stimulus(4'b1011, 0, 0);
        tick(2);
        check_output("prio_hold_valid", int'(irq_valid), 1);
        check_output("prio_hold_id", int'(irq_id), 1);
        apply_stimulus(4'b1011, 1, 0);
        tick(1);
        check_output("prio_idle_gap", int'(irq_valid), 0);
        apply_stimulus(4'b1011, 0, 0);
        tick(1);
        check_output("prio_second_id", int'(irq_id), 3);
        apply_stimulus(4'b1011, 1, 0);
        tick(1);
        apply_stimulus(4'b1011, 0, 0);
        tick(1);
        check_output("prio_third_id", int'(irq_id), 0);
        apply_stimulus(4'b1011, 1, 0);
        tick(1);
        check_output("prio_count", int'(grant_count), 4);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);

        // Overrun on line 2
        apply_stimulus(4'b0100, 0, 0);
        tick(2);
        check_output("ovr_grant_id", int'(irq_id), 2);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);
        apply_stimulus(4'b0100, 0, 0);
        tick(1);
        check_output("ovr_set", int'(overrun), 1);
        check_output("ovr_pending", int'(pending), 4'b0100);
        apply_stimulus(4'b0100, 0, 1);
        tick(1);
        check_output("ovr_cleared", int'(overrun), 0);
        apply_stimulus(4'b0100, 1, 0);
        tick(1);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);
        check_output("ovr_count", int'(grant_count), 5);

        // Ack coinciding with a new edge on the granted line
        apply_stimulus(4'b0010, 0, 0);
        tick(2);
        check_output("sim_grant_id", int'(irq_id), 1);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);
        apply_stimulus(4'b0010, 1, 0);
        tick(1);
        check_output("sim_pending", int'(pending), 4'b0010);
        check_output("sim_overrun", int'(overrun), 0);
        check_output("sim_valid_low", int'(irq_valid), 0);
        apply_stimulus(4'b0010, 0, 0);
        tick(1);
        check_output("sim_regrant_valid", int'(irq_valid), 1);
        check_output("sim_regrant_id", int'(irq_id), 1);
        apply_stimulus(4'b0010, 1, 0);
        tick(1);
        apply_stimulus(4'b0000, 0, 0);
        tick(1);
        check_output("sim_count", int'(grant_count), 7);

        // Stray acks while idle
        apply_stimulus(4'b0000, 1, 0);
        tick(3);
        apply_stimulus(4'b0000, 0, 0);
        check_output("stray_count", int'(grant_count), 7);
        check_output("stray_pending", int'(pending), 0);

        // 249 more grants take the counter from 7 around to 0
        for (int n = 0; n < 249; n++) begin
            apply_stimulus(4'b0001, 0, 0);
            wait_valid(8);
            apply_stimulus(4'b0001, 1, 0);
            tick(1);
            apply_stimulus(4'b0000, 0, 0);
            tick(1);
        end
        check_output("wrap_count", int'(grant_count), 0);

        // Reset in the middle of a grant, request still held afterwards
        apply_stimulus(4'b0100, 0, 0);
        wait_valid(8);
        rst = 1'b1;
        #1;
        check_output("rst_mid_valid", int'(irq_valid), 0);
        check_output("rst_mid_pending", int'(pending), 0);
        check_output("rst_mid_count", int'(grant_count), 0);
        check_output("rst_mid_id", int'(irq_id), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_output("rst_after_pending", int'(pending), 4'b0100);
        tick(1);
        check_output("rst_after_valid", int'(irq_valid), 1);
        check_output("rst_after_id", int'(irq_id), 2);
        apply_stimulus(4'b0100, 1, 0);
        tick(1);
        apply_stimulus(4'b0000, 0, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
